// File: rtl/kf8255_pkg.sv
// Shared types and control-word field positions for the KF8255 PPI Group A logic.
// Contents: Group A mode enum, port A handshake state enum, control-word bit
// positions for mode-set and bit set/reset words, and the port C bit indices
// that carry INTE_A in Mode 1 input and output.
package kf8255_pkg;

  localparam int unsigned DATA_W     = 8;

  // Control-word field positions
  localparam int unsigned MODE_SET   = 7;
  localparam int unsigned GA_MODE_HI = 6;
  localparam int unsigned GA_MODE_LO = 5;
  localparam int unsigned PA_DIR     = 4;
  localparam int unsigned BSR_BIT_HI = 3;
  localparam int unsigned BSR_BIT_LO = 1;
  localparam int unsigned BSR_VAL    = 0;
  localparam int unsigned BSR_BIT_W  = BSR_BIT_HI - BSR_BIT_LO + 1;

  // Port C bits that hold INTE_A in Mode 1
  localparam int unsigned INTE_IN    = 4;
  localparam int unsigned INTE_OUT   = 6;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } kf8255_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } kf8255_hs_state_t;

endpackage

// File: rtl/kf8255_edge_detect.sv
// Registered edge detector for one handshake pin, with an optional 2-flop
// synchronizer ahead of the sampling register.
// Parameters: SYNC_EN   - 1 inserts the 2-flop synchronizer (adds 2 clocks)
//             RESET_VAL - idle level of the pin, loaded into all flops on reset
// Ports: clock, reset_n (async active-low), pin (raw level),
//        rise / fall (one-cycle pulses, combinational from the two sample flops)
module kf8255_edge_detect #(
  parameter bit SYNC_EN   = 1'b0,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic sampled;
  logic sampled_d;

  if (SYNC_EN) begin : g_sync
    logic [1:0] sync_q;

    // Two metastability flops, then the sampling register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync_q  <= {2{RESET_VAL}};
        sampled <= RESET_VAL;
      end else begin
        sync_q  <= {sync_q[0], pin};
        sampled <= sync_q[1];
      end
    end
  end else begin : g_direct
    // Pin is already synchronous to clock: single sampling register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sampled <= RESET_VAL;
      end else begin
        sampled <= pin;
      end
    end
  end

  // Previous sample for edge comparison
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sampled_d <= RESET_VAL;
    end else begin
      sampled_d <= sampled;
    end
  end

  assign rise = sampled & ~sampled_d;
  assign fall = ~sampled & sampled_d;

endmodule

// File: rtl/kf8255_port_a_handshake.sv
// KF8255 port A data path and Mode 0 / Mode 1 strobed handshake engine.
// Inputs : clock, reset_n (async active-low), internal_data_bus, write_port_a,
//          read_port_a (level), write_control, port_a_in, stb_n (PC4), ack_n (PC6)
// Outputs: port_a_out, port_a_io (1 = drive pins), read_data_a (combinational),
//          ibf_a (PC5), obf_a_n (PC7), intr_a (PC3), inte_a, mode1_a
// Build option: KF8255_PORTA_PIN_SYNC_EN adds a 2-flop synchronizer on stb_n,
// ack_n and port_a_in (pin-to-flag latency 4 clocks instead of 2).
module kf8255_port_a_handshake
  import kf8255_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] internal_data_bus,
  input  logic              write_port_a,
  input  logic              read_port_a,
  input  logic              write_control,
  input  logic [DATA_W-1:0] port_a_in,
  input  logic              stb_n,
  input  logic              ack_n,
  output logic [DATA_W-1:0] port_a_out,
  output logic              port_a_io,
  output logic [DATA_W-1:0] read_data_a,
  output logic              ibf_a,
  output logic              obf_a_n,
  output logic              intr_a,
  output logic              inte_a,
  output logic              mode1_a
);

`ifdef KF8255_PORTA_PIN_SYNC_EN
  localparam bit PIN_SYNC = 1'b1;
`else
  localparam bit PIN_SYNC = 1'b0;
`endif

  logic stb_rise, stb_fall, ack_rise, ack_fall, rd_rise, rd_fall;
  logic [DATA_W-1:0] pin_data;

  kf8255_mode_t      mode_q, mode_d;
  kf8255_hs_state_t  state_q, state_d;
  logic              dir_in_q, dir_in_d;
  logic [DATA_W-1:0] in_latch_q, in_latch_d;
  logic [DATA_W-1:0] port_a_out_d;
  logic              ibf_d, obf_n_d, intr_d, inte_d;

  logic                 mode_set, bsr, bsr_hit, m1_in, m1_out;
  logic [BSR_BIT_W-1:0] bsr_bit;

`ifdef KF8255_PORTA_PIN_SYNC_EN
  logic [DATA_W-1:0] pa_sync_q1, pa_sync_q2;

  // Data synchronizer, aligned with the strobe synchronizer depth
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pa_sync_q1 <= '0;
      pa_sync_q2 <= '0;
    end else begin
      pa_sync_q1 <= port_a_in;
      pa_sync_q2 <= pa_sync_q1;
    end
  end

  assign pin_data = pa_sync_q2;
`else
  assign pin_data = port_a_in;
`endif

  kf8255_edge_detect #(.SYNC_EN(PIN_SYNC), .RESET_VAL(1'b1)) u_stb_edge (
    .clock(clock), .reset_n(reset_n), .pin(stb_n), .rise(stb_rise), .fall(stb_fall)
  );

  kf8255_edge_detect #(.SYNC_EN(PIN_SYNC), .RESET_VAL(1'b1)) u_ack_edge (
    .clock(clock), .reset_n(reset_n), .pin(ack_n), .rise(ack_rise), .fall(ack_fall)
  );

  // read_port_a comes from the bus logic and is already synchronous
  kf8255_edge_detect #(.SYNC_EN(1'b0), .RESET_VAL(1'b0)) u_rd_edge (
    .clock(clock), .reset_n(reset_n), .pin(read_port_a), .rise(rd_rise), .fall(rd_fall)
  );

  // Control-word decode
  assign mode_set = write_control & internal_data_bus[MODE_SET];
  assign bsr      = write_control & ~internal_data_bus[MODE_SET];
  assign bsr_bit  = internal_data_bus[BSR_BIT_HI:BSR_BIT_LO];
  assign m1_in    = (mode_q == MODE1) & dir_in_q;
  assign m1_out   = (mode_q == MODE1) & ~dir_in_q;
  assign bsr_hit  = bsr & ((m1_in  & (bsr_bit == BSR_BIT_W'(INTE_IN))) |
                           (m1_out & (bsr_bit == BSR_BIT_W'(INTE_OUT))));

  assign mode1_a   = (mode_q == MODE1);
  assign port_a_io = ~dir_in_q;

  // State and data registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      dir_in_q   <= 1'b1;
      in_latch_q <= '0;
      port_a_out <= '0;
      ibf_a      <= 1'b0;
      obf_a_n    <= 1'b1;
      intr_a     <= 1'b0;
      inte_a     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dir_in_q   <= dir_in_d;
      in_latch_q <= in_latch_d;
      port_a_out <= port_a_out_d;
      ibf_a      <= ibf_d;
      obf_a_n    <= obf_n_d;
      intr_a     <= intr_d;
      inte_a     <= inte_d;
    end
  end

  // Handshake next state; input mode is paced by STB/read, output by write/ACK
  always_comb begin
    state_d = state_q;
    if (mode_set) begin
      state_d = IDLE;
    end else if (m1_in) begin
      case (state_q)
        IDLE:    if (stb_fall) state_d = FULL;
        FULL:    if (stb_rise) state_d = PEND;
        DRAIN:   if (rd_fall)  state_d = stb_fall ? FULL : IDLE;
        default: state_d = state_q;
      endcase
      if (rd_rise) state_d = DRAIN;
    end else if (m1_out) begin
      case (state_q)
        FULL:    if (ack_fall) state_d = DRAIN;
        DRAIN:   if (ack_rise) state_d = PEND;
        default: state_d = state_q;
      endcase
      if (write_port_a) state_d = FULL;
    end else begin
      state_d = IDLE;
    end
  end

  // Flag and data updates; later assignments win on coincident events
  always_comb begin
    mode_d       = mode_q;
    dir_in_d     = dir_in_q;
    in_latch_d   = in_latch_q;
    port_a_out_d = port_a_out;
    ibf_d        = ibf_a;
    obf_n_d      = obf_a_n;
    intr_d       = intr_a;
    inte_d       = inte_a;

    if (mode_set) begin
      mode_d       = (internal_data_bus[GA_MODE_HI] | internal_data_bus[GA_MODE_LO]) ? MODE1 : MODE0;
      dir_in_d     = internal_data_bus[PA_DIR];
      in_latch_d   = '0;
      port_a_out_d = '0;
      ibf_d        = 1'b0;
      obf_n_d      = 1'b1;
      intr_d       = 1'b0;
      inte_d       = 1'b0;
    end else begin
      if (bsr_hit) inte_d = internal_data_bus[BSR_VAL];
      if (write_port_a) port_a_out_d = internal_data_bus;

      if (m1_in) begin
        if (stb_rise && inte_a && ibf_a) intr_d = 1'b1;
        if (rd_rise) intr_d = 1'b0;
        if (rd_fall) ibf_d = 1'b0;
        // A strobe coincident with read completion keeps the buffer full
        if (stb_fall) begin
          in_latch_d = pin_data;
          ibf_d      = 1'b1;
        end
      end else if (m1_out) begin
        if (ack_fall) obf_n_d = 1'b1;
        if (ack_rise && inte_a && obf_a_n) intr_d = 1'b1;
        // A new write overrides a coincident ACK completion
        if (write_port_a) begin
          obf_n_d = 1'b0;
          intr_d  = 1'b0;
        end
      end
    end
  end

  // CPU read data path
  always_comb begin
    read_data_a = port_a_out;
    if (dir_in_q) begin
      read_data_a = (mode_q == MODE1) ? in_latch_q : port_a_in;
    end
  end

endmodule
